// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
//   pc_src_t : next-PC source select driven by the control unit
//   PC_W_DEF : default PC width in bits
package pc_pkg;

  localparam int unsigned PC_W_DEF = 11;

  typedef enum logic [2:0] {
    SEQ  = 3'b000,
    BEQ  = 3'b001,
    JRRA = 3'b010,
    JAL  = 3'b011,
    CALL = 3'b100,
    RET  = 3'b101
  } pc_src_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack held in a circular buffer.
// A push onto a full stack overwrites the oldest entry and keeps the count at DEPTH.
// A pop from an empty stack is ignored.
// A push takes priority if push and pop are both asserted.
//   clk, rst : clock, asynchronous active-high reset (discards all entries)
//   push/din : write din as the new top of stack
//   pop      : discard the top of stack
//   top      : current top-of-stack value (valid when !empty)
//   count    : number of valid entries, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
module ras_stack #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == CntW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign top   = mem_q[ptr_q];

  // The pointer wraps naturally because DEPTH is a power of two.
  // Once the stack is full, advancing the pointer lands on the oldest entry.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PtrW'(1);
      if (!full) cnt_d = cnt_q + CntW'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset: count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_d] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit.
// Holds the PC, computes the next PC from pc_src, and manages call/return through
// an internal return-address stack.
//   clk, rst    : clock, asynchronous active-high reset
//   stall       : hold the PC and stack; flags are not set
//   pc_src      : next-PC select (pc_src_t encodings)
//   br_taken    : branch condition for BEQ
//   br_off      : signed branch offset
//   jmp_target  : absolute target for JRRA/JAL/CALL
//   err_clr     : clear the sticky error flags
//   pc          : registered PC
//   pc_next     : combinational next PC, before stall gating
//   ras_count   : number of valid stack entries
//   ras_ovf     : sticky flag, set on a push onto a full stack
//   ras_unf     : sticky flag, set on a pop from an empty stack
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_VEC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [2:0]                 pc_src,
  input  logic                       br_taken,
  input  logic [PC_W-1:0]            br_off,
  input  logic [PC_W-1:0]            jmp_target,
  input  logic                       err_clr,
  output logic [PC_W-1:0]            pc,
  output logic [PC_W-1:0]            pc_next,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  pc_src_t         src;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus1, pc_br, ras_top;
  logic            ras_ovf_q, ras_ovf_d;
  logic            ras_unf_q, ras_unf_d;
  logic            ras_push, ras_pop, ras_full, ras_empty;
  logic            is_call, is_ret;

  assign src      = pc_src_t'(pc_src);
  assign pc_plus1 = pc_q + PC_W'(1);
  // Two's-complement add: a negative offset wraps back modulo 2^PC_W.
  assign pc_br    = pc_q + br_off;
  assign is_call  = (src == CALL);
  assign is_ret   = (src == RET);

  always_comb begin
    pc_next = pc_plus1;
    unique case (src)
      SEQ:              pc_next = pc_plus1;
      BEQ:              pc_next = br_taken ? pc_br : pc_plus1;
      JRRA, JAL, CALL:  pc_next = jmp_target;
      RET:              pc_next = ras_empty ? pc_plus1 : ras_top;
      default:          pc_next = pc_plus1;
    endcase
  end

  assign ras_push = !stall && is_call;
  assign ras_pop  = !stall && is_ret && !ras_empty;

  always_comb begin
    pc_d      = stall ? pc_q : pc_next;
    ras_ovf_d = err_clr ? 1'b0 : ras_ovf_q;
    ras_unf_d = err_clr ? 1'b0 : ras_unf_q;
    // A new error overrides a clear arriving on the same edge.
    if (ras_push && ras_full)             ras_ovf_d = 1'b1;
    if (!stall && is_ret && ras_empty)    ras_unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= PC_W'(RESET_VEC);
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ras_ovf_q <= ras_ovf_d;
      ras_unf_q <= ras_unf_d;
    end
  end

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus1),
    .top   (ras_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty)
  );

  assign pc      = pc_q;
  assign ras_ovf = ras_ovf_q;
  assign ras_unf = ras_unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (PC_W=11, RAS_DEPTH=4, RESET_VEC=0).
// Expected state is queued when each step is driven and compared after the edge.
module tb_pc_sequencer;

  localparam logic [2:0] S_SEQ  = 3'b000;
  localparam logic [2:0] S_BEQ  = 3'b001;
  localparam logic [2:0] S_JAL  = 3'b011;
  localparam logic [2:0] S_CALL = 3'b100;
  localparam logic [2:0] S_RET  = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  pc_src = 3'b000;
  logic        br_taken = 1'b0;
  logic [10:0] br_off = '0;
  logic [10:0] jmp_target = '0;
  logic        err_clr = 1'b0;
  logic [10:0] pc;
  logic [10:0] pc_next;
  logic [2:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;

  typedef struct {
    string       tag;
    logic [10:0] pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W      (11),
    .RAS_DEPTH (4),
    .RESET_VEC (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .pc_src     (pc_src),
    .br_taken   (br_taken),
    .br_off     (br_off),
    .jmp_target (jmp_target),
    .err_clr    (err_clr),
    .pc         (pc),
    .pc_next    (pc_next),
    .ras_count  (ras_count),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [10:0] e_pc, input logic [2:0] e_cnt,
                              input logic e_ovf, input logic e_unf);
    exp_t e;
    e.tag = tag; e.pc = e_pc; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf;
    sb.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      n_tests--;
      e = sb.pop_front();
      chk({e.tag, ".pc"},  32'(pc),        32'(e.pc));
      chk({e.tag, ".cnt"}, 32'(ras_count), 32'(e.cnt));
      chk({e.tag, ".ovf"}, 32'(ras_ovf),   32'(e.ovf));
      chk({e.tag, ".unf"}, 32'(ras_unf),   32'(e.unf));
    end
  endtask

  task automatic drive(input logic [2:0] src, input logic taken, input logic [10:0] off,
                       input logic [10:0] tgt, input logic stl, input logic clr);
    pc_src = src; br_taken = taken; br_off = off; jmp_target = tgt; stall = stl; err_clr = clr;
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  task automatic step(input string tag, input logic [2:0] src, input logic taken,
                      input logic [10:0] off, input logic [10:0] tgt, input logic stl,
                      input logic clr, input logic [10:0] e_pc, input logic [2:0] e_cnt,
                      input logic e_ovf, input logic e_unf);
    drive(src, taken, off, tgt, stl, clr);
    expect_state(tag, e_pc, e_cnt, e_ovf, e_unf);
    tick_check();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_state("reset", 11'd0, 3'd0, 1'b0, 1'b0);
    compare_pop();
    rst = 1'b0;

    // Sequential and wrap-around
    step("seq1", S_SEQ, 0, 0, 0, 0, 0, 11'd1, 3'd0, 0, 0);
    step("seq2", S_SEQ, 0, 0, 0, 0, 0, 11'd2, 3'd0, 0, 0);
    step("seq3", S_SEQ, 0, 0, 0, 0, 0, 11'd3, 3'd0, 0, 0);
    step("jal2047", S_JAL, 0, 0, 11'd2047, 0, 0, 11'd2047, 3'd0, 0, 0);
    step("seqwrap", S_SEQ, 0, 0, 0, 0, 0, 11'd0, 3'd0, 0, 0);

    // Branches
    step("jal5a", S_JAL, 0, 0, 11'd5, 0, 0, 11'd5, 3'd0, 0, 0);
    step("beq_tk", S_BEQ, 1, 11'h7FE, 0, 0, 0, 11'd3, 3'd0, 0, 0);
    step("jal5b", S_JAL, 0, 0, 11'd5, 0, 0, 11'd5, 3'd0, 0, 0);
    step("beq_nt", S_BEQ, 0, 11'h7FE, 0, 0, 0, 11'd6, 3'd0, 0, 0);

    // Back-to-back call/return
    step("jal10", S_JAL, 0, 0, 11'd10, 0, 0, 11'd10, 3'd0, 0, 0);
    step("call100", S_CALL, 0, 0, 11'd100, 0, 0, 11'd100, 3'd1, 0, 0);
    step("ret11", S_RET, 0, 0, 0, 0, 0, 11'd11, 3'd0, 0, 0);

    // Overflow: five nested calls from 0, 20, 40, 60, 80
    step("jal0", S_JAL, 0, 0, 11'd0, 0, 0, 11'd0, 3'd0, 0, 0);
    step("callA", S_CALL, 0, 0, 11'd20, 0, 0, 11'd20, 3'd1, 0, 0);
    step("callB", S_CALL, 0, 0, 11'd40, 0, 0, 11'd40, 3'd2, 0, 0);
    step("callC", S_CALL, 0, 0, 11'd60, 0, 0, 11'd60, 3'd3, 0, 0);
    step("callD", S_CALL, 0, 0, 11'd80, 0, 0, 11'd80, 3'd4, 0, 0);
    step("callE", S_CALL, 0, 0, 11'd200, 0, 0, 11'd200, 3'd4, 1, 0);
    step("ret81", S_RET, 0, 0, 0, 0, 0, 11'd81, 3'd3, 1, 0);
    step("ret61", S_RET, 0, 0, 0, 0, 0, 11'd61, 3'd2, 1, 0);
    step("ret41", S_RET, 0, 0, 0, 0, 0, 11'd41, 3'd1, 1, 0);
    step("ret21", S_RET, 0, 0, 0, 0, 0, 11'd21, 3'd0, 1, 0);
    step("ret_unf", S_RET, 0, 0, 0, 0, 0, 11'd22, 3'd0, 1, 1);

    // Stalled call: nothing changes, pc_next still driven
    drive(S_CALL, 0, 0, 11'd300, 1, 0);
    #1;
    chk("stall_pcnext", 32'(pc_next), 32'd300);
    expect_state("stall_call", 11'd22, 3'd0, 1, 1);
    tick_check();

    // Clear together with a new underflow: unf stays, ovf clears
    step("clr_ret", S_RET, 0, 0, 0, 0, 1, 11'd23, 3'd0, 0, 1);
    step("clr_only", S_SEQ, 0, 0, 0, 0, 1, 11'd24, 3'd0, 0, 0);
    step("stall_ret", S_RET, 0, 0, 0, 1, 0, 11'd24, 3'd0, 0, 0);

    // Asynchronous reset with three entries on the stack
    step("call30", S_CALL, 0, 0, 11'd30, 0, 0, 11'd30, 3'd1, 0, 0);
    step("call40", S_CALL, 0, 0, 11'd40, 0, 0, 11'd40, 3'd2, 0, 0);
    step("call50", S_CALL, 0, 0, 11'd50, 0, 0, 11'd50, 3'd3, 0, 0);
    drive(S_SEQ, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    expect_state("async_rst", 11'd0, 3'd0, 0, 0);
    compare_pop();
    #1;
    rst = 1'b0;
    step("post_rst", S_SEQ, 0, 0, 0, 0, 0, 11'd1, 3'd0, 0, 0);
    step("post_ret", S_RET, 0, 0, 0, 0, 0, 11'd2, 3'd0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
